// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//
// Front end of the 4-bit ALU. Operands A, B and the function code are loaded
// one nibble at a time from a shared bus, qualified by an asynchronous pin
// strobe (load_i). A second strobe (exec_i) starts an execute: the operands
// are frozen on the ALU inputs for SETTLE_CYCLES cycles, after which the ALU
// output is captured into a holding register for the 7-segment path. In
// accumulator mode the captured result is also written back into A.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   ena          in   design enable; when low only the synchronisers move
//   data_in      in   nibble to load
//   sel          in   load target: 00 = A, 01 = B, 10 = func, 11 = none
//   load_i       in   asynchronous load strobe (rising edge acts)
//   exec_i       in   asynchronous execute strobe (rising edge acts)
//   acc_mode     in   write the captured result back into A
//   alu_y        in   result from the ALU
//   alu_a        out  A register to the ALU
//   alu_b        out  B register to the ALU
//   alu_func     out  function register to the ALU
//   result       out  captured result
//   result_valid out  result holds a completed execute
//   busy         out  high in SETTLE and CAPTURE
//   ovr          out  sticky: a strobe was dropped while busy
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int                 WIDTH         = 4,
    parameter int                 FUNC_W        = 4,
    parameter int                 SETTLE_CYCLES = 1,
    parameter logic [FUNC_W-1:0]  RESET_FUNC    = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [1:0]        sel,
    input  logic              load_i,
    input  logic              exec_i,
    input  logic              acc_mode,
    input  logic [WIDTH-1:0]  alu_y,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              ovr
);

    localparam int          CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Synchroniser chains: bit 0 = s1, bit 1 = s2, bit 2 = edge register s3.
    logic [2:0]        r_load_sync;
    logic [2:0]        r_exec_sync;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [FUNC_W-1:0] r_func;
    logic [WIDTH-1:0]  r_result;
    logic              r_valid;
    logic              r_ovr;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0]  w_a_nxt;
    logic [WIDTH-1:0]  w_b_nxt;
    logic [FUNC_W-1:0] w_func_nxt;
    logic [WIDTH-1:0]  w_result_nxt;
    logic              w_valid_nxt;
    logic              w_ovr_nxt;

    logic              w_load_pls;
    logic              w_exec_pls;

    // One-cycle pulse on the first cycle the synchronised strobe is seen high;
    // a strobe held high therefore yields exactly one pulse.
    assign w_load_pls = r_load_sync[1] & ~r_load_sync[2];
    assign w_exec_pls = r_exec_sync[1] & ~r_exec_sync[2];

    // Synchronisers run regardless of ena so that a strobe seen while
    // disabled is consumed and cannot fire late when ena returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_sync <= '0;
            r_exec_sync <= '0;
        end else begin
            r_load_sync <= {r_load_sync[1:0], load_i};
            r_exec_sync <= {r_exec_sync[1:0], exec_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_func   <= RESET_FUNC;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_func   <= w_func_nxt;
            r_result <= w_result_nxt;
            r_valid  <= w_valid_nxt;
            r_ovr    <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_func_nxt   = r_func;
        w_result_nxt = r_result;
        w_valid_nxt  = r_valid;
        w_ovr_nxt    = r_ovr;

        // With ena low every pulse is thrown away and all state holds.
        if (ena) begin
            unique case (r_state)
                IDLE: begin
                    // A load and an exec on the same cycle both act, so the
                    // freshly loaded operand is what the ALU sees in SETTLE.
                    if (w_load_pls) begin
                        unique case (sel)
                            2'b00:   w_a_nxt    = data_in;
                            2'b01:   w_b_nxt    = data_in;
                            2'b10:   w_func_nxt = data_in[FUNC_W-1:0];
                            default: ;
                        endcase
                    end
                    if (w_exec_pls) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = CNT_INIT;
                        w_valid_nxt = 1'b0;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = CAPTURE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    w_result_nxt = alu_y;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = IDLE;
                    if (acc_mode) begin
                        w_a_nxt = alu_y;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            // Any strobe while busy is lost; remember that it happened.
            if ((r_state != IDLE) && (w_load_pls || w_exec_pls)) begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_func     = r_func;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign busy         = (r_state != IDLE);
    assign ovr          = r_ovr;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic [1:0] sel;
    logic       load_i;
    logic       exec_i;
    logic       acc_mode;

    logic [3:0] alu_y1, alu_a1, alu_b1, alu_func1, result1;
    logic       result_valid1, busy1, ovr1;
    logic [3:0] alu_y2, alu_a2, alu_b2, alu_func2, result2;
    logic       result_valid2, busy2, ovr2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU downstream of each sequencer: 0000 add, 0001 sub,
    // anything else passes A through.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b0001: return a - b;
            default: return a;
        endcase
    endfunction

    assign alu_y1 = alu_model(alu_a1, alu_b1, alu_func1);
    assign alu_y2 = alu_model(alu_a2, alu_b2, alu_func2);

    alu_operand_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .sel(sel),
        .load_i(load_i), .exec_i(exec_i), .acc_mode(acc_mode), .alu_y(alu_y1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_func(alu_func1), .result(result1),
        .result_valid(result_valid1), .busy(busy1), .ovr(ovr1)
    );

    alu_operand_sequencer #(.SETTLE_CYCLES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .sel(sel),
        .load_i(load_i), .exec_i(exec_i), .acc_mode(acc_mode), .alu_y(alu_y2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_func(alu_func2), .result(result2),
        .result_valid(result_valid2), .busy(busy2), .ovr(ovr2)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full load handshake: the write lands on the third edge after the rise,
    // then the strobe is dropped long enough for the edge register to clear.
    task automatic do_load(input logic [1:0] s, input logic [3:0] d);
        sel     = s;
        data_in = d;
        load_i  = 1'b1;
        cyc(3);
        load_i  = 1'b0;
        cyc(3);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        data_in  = 4'h0;
        sel      = 2'b11;
        load_i   = 1'b0;
        exec_i   = 1'b0;
        acc_mode = 1'b0;
        cyc(3);

        // Reset state
        chk("rst_a",     {4'h0, alu_a1},        8'h00);
        chk("rst_b",     {4'h0, alu_b1},        8'h00);
        chk("rst_func",  {4'h0, alu_func1},     8'h0F);
        chk("rst_res",   {4'h0, result1},       8'h00);
        chk("rst_flags", {5'h0, result_valid1, busy1, ovr1}, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        // Basic add: 2 + 14 wraps to 0 in 4 bits
        do_load(2'b00, 4'b0010);
        do_load(2'b01, 4'b1110);
        do_load(2'b10, 4'b0000);
        exec_i = 1'b1;
        cyc(3);
        chk("add_busy0",  {7'h0, busy1},          8'h01);
        chk("add_vld0",   {7'h0, result_valid1},  8'h00);
        chk("add_ops0",   {alu_a1, alu_b1},       8'h2E);
        cyc(1);
        chk("add_busy1",  {7'h0, busy1},          8'h01);
        chk("add_ops1",   {alu_a1, alu_func1},    8'h20);
        cyc(1);
        chk("add_busy2",  {7'h0, busy1},          8'h00);
        chk("add_vld",    {7'h0, result_valid1},  8'h01);
        chk("add_res",    {4'h0, result1},        8'h00);
        exec_i = 1'b0;
        cyc(3);

        // Sub and sel = 11 no-write
        do_load(2'b00, 4'b0010);
        do_load(2'b01, 4'b0100);
        do_load(2'b10, 4'b0001);
        do_load(2'b11, 4'b1111);
        chk("sel11_ab",   {alu_a1, alu_b1},       8'h24);
        chk("sel11_func", {4'h0, alu_func1},      8'h01);
        chk("sel11_keep", {3'h0, result_valid1, result1}, 8'h10);
        exec_i = 1'b1;
        cyc(5);
        chk("sub_res",    {3'h0, result_valid1, result1}, 8'h1E);
        exec_i = 1'b0;
        cyc(3);

        // Accumulator chain 1+1, +1, +1
        acc_mode = 1'b1;
        do_load(2'b00, 4'h1);
        do_load(2'b01, 4'h1);
        do_load(2'b10, 4'h0);
        for (int k = 0; k < 3; k++) begin
            exec_i = 1'b1;
            cyc(5);
            chk($sformatf("acc_res%0d", k), {3'h0, result_valid1, result1}, 8'(16 + k + 2));
            chk($sformatf("acc_a%0d", k),   {4'h0, alu_a1},                 8'(k + 2));
            exec_i = 1'b0;
            cyc(5);
        end
        chk("acc_ovr", {7'h0, ovr1}, 8'h00);
        acc_mode = 1'b0;

        // Overrun on the SETTLE_CYCLES = 4 instance
        do_load(2'b00, 4'h3);
        chk("ovr_pre", {7'h0, ovr2}, 8'h00);
        exec_i  = 1'b1;
        cyc(1);
        sel     = 2'b00;
        data_in = 4'b0111;
        load_i  = 1'b1;
        cyc(2);
        chk("ovr_busy", {7'h0, busy2}, 8'h01);
        cyc(1);
        chk("ovr_set",  {7'h0, ovr2},  8'h01);
        chk("ovr_a",    {4'h0, alu_a2}, 8'h03);
        cyc(3);
        chk("ovr_wait", {6'h0, busy2, result_valid2}, 8'h02);
        cyc(1);
        chk("ovr_done", {2'h0, busy2, result_valid2, result2}, 8'h14);
        exec_i = 1'b0;
        load_i = 1'b0;
        cyc(3);
        chk("ovr_sticky", {3'h0, ovr2, alu_a2}, 8'h13);

        // Reset during SETTLE aborts the execute
        exec_i = 1'b1;
        cyc(4);
        chk("rst_mid_busy", {7'h0, busy2}, 8'h01);
        rst_n  = 1'b0;
        exec_i = 1'b0;
        cyc(1);
        chk("rst_mid_ops",  {alu_a2, alu_b2},  8'h00);
        chk("rst_mid_func", {4'h0, alu_func2}, 8'h0F);
        chk("rst_mid_flg",  {1'h0, busy2, result_valid2, ovr2, result2}, 8'h00);
        rst_n = 1'b1;
        cyc(8);
        chk("rst_no_cap",   {6'h0, busy2, result_valid2}, 8'h00);

        // Enable low: exec strobe discarded, no overrun
        ena    = 1'b0;
        exec_i = 1'b1;
        cyc(5);
        chk("ena_idle", {6'h0, busy1, ovr1}, 8'h00);
        exec_i = 1'b0;
        cyc(3);
        ena = 1'b1;
        cyc(3);
        chk("ena_after", {5'h0, busy1, ovr1, result_valid1}, 8'h00);

        // Strobe held high: one load, on the third edge
        sel     = 2'b00;
        data_in = 4'h5;
        load_i  = 1'b1;
        cyc(2);
        chk("hold_e2", {4'h0, alu_a1}, 8'h00);
        cyc(1);
        chk("hold_e3", {4'h0, alu_a1}, 8'h05);
        data_in = 4'h9;
        cyc(17);
        chk("hold_once", {3'h0, ovr1, alu_a1}, 8'h05);
        load_i = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
